mmio_led_bank: RTL and testbench

MMIO_LED_BANK -- requirements
Module: mmio_led_bank

---
 rtl/mmio_led_bank_pkg.sv | 44 ++++
 rtl/led_blink_timer.sv | 38 +++
 rtl/mmio_led_bank.sv | 131 +++++++++++++
 tb/tb_mmio_led_bank.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mmio_led_bank_pkg.sv
// Register map and decode helper for the MMIO LED bank.
// Offsets are byte offsets within the 256-byte window.
package mmio_led_bank_pkg;

  localparam int unsigned WINDOW_BYTES    = 256;
  localparam logic [7:0]  OFF_PERBIT_LAST = 8'h7C;
  localparam logic [7:0]  OFF_WORD        = 8'h80;
  localparam logic [7:0]  OFF_SET         = 8'h84;
  localparam logic [7:0]  OFF_CLR         = 8'h88;
  localparam logic [7:0]  OFF_TGL         = 8'h8C;
  localparam logic [7:0]  OFF_BLINK_MASK  = 8'h90;
  localparam logic [7:0]  OFF_BLINK_DIV   = 8'h94;

  typedef enum logic [2:0] {
    REG_PERBIT,
    REG_WORD,
    REG_SET,
    REG_CLR,
    REG_TGL,
    REG_BMASK,
    REG_BDIV,
    REG_NONE
  } reg_sel_e;

  function automatic reg_sel_e decode_offset(input logic [7:0] off);
    reg_sel_e sel;
    sel = REG_NONE;
    if (off <= OFF_PERBIT_LAST) begin
      sel = REG_PERBIT;
    end else begin
      case (off)
        OFF_WORD:       sel = REG_WORD;
        OFF_SET:        sel = REG_SET;
        OFF_CLR:        sel = REG_CLR;
        OFF_TGL:        sel = REG_TGL;
        OFF_BLINK_MASK: sel = REG_BMASK;
        OFF_BLINK_DIV:  sel = REG_BDIV;
        default:        sel = REG_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/led_blink_timer.sv
// Free-running blink divider: phase flips every div cycles; div=0 parks phase at 1.
// Used only when MMIO_LED_BANK_BLINK_EN is defined.
module led_blink_timer (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic [31:0] div,
  input  logic        restart,
  output logic        phase
);

  logic [31:0] cnt_q, cnt_d;
  logic        phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q + 32'd1;
    phase_d = phase_q;
    if (restart || (div == 32'd0)) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == div - 32'd1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/mmio_led_bank.sv
// Memory-mapped LED register bank with word, per-bit and set/clear/toggle access.
// Define MMIO_LED_BANK_BLINK_EN to add the BLINK_MASK/BLINK_DIV blink feature.
module mmio_led_bank
  import mmio_led_bank_pkg::*;
#(
  parameter int          N_LEDS    = 24,
  parameter logic [31:0] BASE_ADDR = 32'hFFFF_0400
) (
  input  logic              sys_clk,
  input  logic              rst,
  input  logic              mmio_read,
  input  logic              mmio_write,
  input  logic [31:0]       mmio_addr,
  input  logic [31:0]       mmio_write_data,
  output logic              mmio_work,
  output logic              mmio_done,
  output logic [31:0]       mmio_read_data,
  output logic [N_LEDS-1:0] leds_pin
);

  logic [N_LEDS-1:0] led_q, led_d;
  logic              done_q, done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       rd_val;
  logic [7:0]        off;
  logic [4:0]        bit_idx;
  logic [N_LEDS-1:0] wdata;
  reg_sel_e          sel;
  logic              accept, do_wr, do_rd;
  logic              unused_bits;

  assign mmio_work = (mmio_addr[31:8] == BASE_ADDR[31:8]);
  assign off       = {mmio_addr[7:2], 2'b00};
  assign bit_idx   = mmio_addr[6:2];
  assign wdata     = mmio_write_data[N_LEDS-1:0];
  assign sel       = decode_offset(off);
  // A completion cycle blocks acceptance, so held requests finish every other cycle.
  assign accept    = mmio_work && (mmio_read || mmio_write) && !done_q;
  assign do_wr     = accept && mmio_write;
  assign do_rd     = accept && mmio_read;
  assign unused_bits = ^{mmio_addr[1:0], mmio_write_data};

`ifdef MMIO_LED_BANK_BLINK_EN
  logic [N_LEDS-1:0] mask_q, mask_d;
  logic [31:0]       div_q, div_d;
  logic              blink_phase;

  led_blink_timer u_timer (
    .sys_clk (sys_clk),
    .rst     (rst),
    .div     (div_q),
    .restart (do_wr && (sel == REG_BDIV)),
    .phase   (blink_phase)
  );

  always_comb begin
    mask_d = mask_q;
    div_d  = div_q;
    if (do_wr && (sel == REG_BMASK)) mask_d = wdata;
    if (do_wr && (sel == REG_BDIV))  div_d  = mmio_write_data;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      mask_q <= '0;
      div_q  <= '0;
    end else begin
      mask_q <= mask_d;
      div_q  <= div_d;
    end
  end

  assign leds_pin = led_q & (~mask_q | {N_LEDS{blink_phase}});
`else
  assign leds_pin = led_q;
`endif

  // Read mux sees only current register state, so a combined read+write returns the old value.
  always_comb begin
    rd_val = '0;
    case (sel)
      REG_PERBIT: begin
        for (int i = 0; i < N_LEDS; i++) begin
          if (bit_idx == 5'(i)) rd_val = {31'b0, led_q[i]};
        end
      end
      REG_WORD:  rd_val = 32'(led_q);
`ifdef MMIO_LED_BANK_BLINK_EN
      REG_BMASK: rd_val = 32'(mask_q);
      REG_BDIV:  rd_val = div_q;
`endif
      default:   rd_val = '0;
    endcase
  end

  always_comb begin
    led_d = led_q;
    if (do_wr) begin
      case (sel)
        REG_PERBIT: begin
          for (int i = 0; i < N_LEDS; i++) begin
            if (bit_idx == 5'(i)) led_d[i] = mmio_write_data[0];
          end
        end
        REG_WORD: led_d = wdata;
        REG_SET:  led_d = led_q | wdata;
        REG_CLR:  led_d = led_q & ~wdata;
        REG_TGL:  led_d = led_q ^ wdata;
        default:  led_d = led_q;
      endcase
    end
    done_d  = accept;
    rdata_d = do_rd ? rd_val : '0;
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      led_q   <= '0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      led_q   <= led_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign mmio_done      = done_q;
  assign mmio_read_data = rdata_q;

endmodule

// File: tb/tb_mmio_led_bank.sv
// Randomized bench for mmio_led_bank against a register-level reference model.
// Blink checks are active when MMIO_LED_BANK_BLINK_EN is defined.
module tb_mmio_led_bank;

  localparam int          N     = 24;
  localparam logic [31:0] BASE  = 32'hFFFF_0400;
  localparam logic [31:0] NMASK = (N == 32) ? 32'hFFFF_FFFF : ((32'd1 << N) - 32'd1);

  logic          sys_clk = 1'b0;
  logic          rst = 1'b1;
  logic          mmio_read = 1'b0, mmio_write = 1'b0;
  logic [31:0]   mmio_addr = '0, mmio_write_data = '0;
  logic          mmio_work, mmio_done;
  logic [31:0]   mmio_read_data;
  logic [N-1:0]  leds_pin;

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  mmio_led_bank #(.N_LEDS(N), .BASE_ADDR(BASE)) dut (
    .sys_clk         (sys_clk),
    .rst             (rst),
    .mmio_read       (mmio_read),
    .mmio_write      (mmio_write),
    .mmio_addr       (mmio_addr),
    .mmio_write_data (mmio_write_data),
    .mmio_work       (mmio_work),
    .mmio_done       (mmio_done),
    .mmio_read_data  (mmio_read_data),
    .leds_pin        (leds_pin)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents plus cycles elapsed since the last blink restart.
  logic [31:0]     m_led = '0, m_mask = '0, m_div = '0, m_rdata = '0;
  bit              m_done = 1'b0;
  longint unsigned m_since = 0;

  function automatic bit m_phase();
    if (m_div == 0) return 1'b1;
    return ((m_since / longint'(m_div)) % 2) == 0;
  endfunction

  function automatic logic [31:0] m_rd(input logic [7:0] off);
    int idx;
    if (off < 8'h80) begin
      idx = int'(off) / 4;
      return (idx < N) ? ((m_led >> idx) & 32'd1) : 32'd0;
    end
    if (off == 8'h80) return m_led;
`ifdef MMIO_LED_BANK_BLINK_EN
    if (off == 8'h90) return m_mask;
    if (off == 8'h94) return m_div;
`endif
    return 32'd0;
  endfunction

  task automatic m_wr(input logic [7:0] off, input logic [31:0] d);
    int idx;
    if (off < 8'h80) begin
      idx = int'(off) / 4;
      if (idx < N) m_led = (m_led & ~(32'd1 << idx)) | ((d & 32'd1) << idx);
    end else if (off == 8'h80) m_led = d & NMASK;
    else if (off == 8'h84) m_led = m_led | (d & NMASK);
    else if (off == 8'h88) m_led = m_led & ~d;
    else if (off == 8'h8C) m_led = m_led ^ (d & NMASK);
`ifdef MMIO_LED_BANK_BLINK_EN
    else if (off == 8'h90) m_mask = d & NMASK;
    else if (off == 8'h94) begin m_div = d; m_since = 0; end
`endif
  endtask

  always @(posedge sys_clk or posedge rst) begin
    logic        acc;
    logic [7:0]  off;
    logic [31:0] rv;
    if (rst) begin
      m_led = '0; m_mask = '0; m_div = '0; m_rdata = '0; m_done = 1'b0; m_since = 0;
    end else begin
      acc = (mmio_addr[31:8] == BASE[31:8]) && (mmio_read || mmio_write) && !m_done;
      off = {mmio_addr[7:2], 2'b00};
      rv  = m_rd(off);
      m_since++;
      if (acc && mmio_write) m_wr(off, mmio_write_data);
      m_rdata = (acc && mmio_read) ? rv : 32'd0;
      m_done  = acc;
    end
  end

  always @(negedge sys_clk) begin
    logic [31:0] exp_leds;
    if (cmp_en) begin
`ifdef MMIO_LED_BANK_BLINK_EN
      exp_leds = m_led & (~m_mask | (m_phase() ? 32'hFFFF_FFFF : 32'd0)) & NMASK;
`else
      exp_leds = m_led;
`endif
      chk("cyc_done", 32'(mmio_done), 32'(m_done));
      chk("cyc_rdata", mmio_read_data, m_rdata);
      chk("cyc_leds", 32'(leds_pin), exp_leds);
      chk("cyc_work", 32'(mmio_work), 32'(mmio_addr[31:8] == BASE[31:8]));
    end
  end

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input bit exp_in);
    @(posedge sys_clk); #2;
    mmio_write = 1'b1; mmio_read = 1'b0; mmio_addr = addr; mmio_write_data = data;
    #1 chk("wr_work", 32'(mmio_work), 32'(exp_in));
    @(posedge sys_clk); #2;
    mmio_write = 1'b0;
    chk("wr_done", 32'(mmio_done), 32'(exp_in));
    @(posedge sys_clk); #2;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    @(posedge sys_clk); #2;
    mmio_read = 1'b1; mmio_write = 1'b0; mmio_addr = addr;
    @(posedge sys_clk); #2;
    mmio_read = 1'b0;
    chk("rd_done", 32'(mmio_done), 32'd1);
    data = mmio_read_data;
    @(posedge sys_clk); #2;
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] dpat [6];
    logic [31:0] rpat [6];
    int r;

    repeat (3) @(posedge sys_clk);
    cmp_en = 1'b1;
    @(negedge sys_clk);
    chk("rst_leds", 32'(leds_pin), 32'd0);
    chk("rst_done", 32'(mmio_done), 32'd0);
    chk("rst_rdata", mmio_read_data, 32'd0);
    @(posedge sys_clk); #2;
    rst = 1'b0;

    wr(BASE + 32'h80, 32'hFFFF_FFFF, 1'b1);
    chk("word_leds", 32'(leds_pin), 32'h00FF_FFFF);
    rd(BASE + 32'h80, v);
    chk("word_read", v, 32'h00FF_FFFF);

    wr(BASE + 32'h80, 32'h0, 1'b1);
    wr(BASE + 32'h84, 32'h5, 1'b1);
    chk("set_leds", 32'(leds_pin), 32'h5);
    wr(BASE + 32'h88, 32'h1, 1'b1);
    chk("clr_leds", 32'(leds_pin), 32'h4);
    wr(BASE + 32'h8C, 32'h3, 1'b1);
    chk("tgl_leds", 32'(leds_pin), 32'h7);
    rd(BASE + 32'h84, v);
    chk("set_read", v, 32'h0);
    rd(BASE + 32'h08, v);
    chk("perbit2_read", v, 32'h1);

    wr(BASE + 32'h80, 32'h0, 1'b1);
    @(posedge sys_clk); #2;
    mmio_read = 1'b1; mmio_write = 1'b1; mmio_addr = BASE; mmio_write_data = 32'h1;
    for (int i = 0; i < 6; i++) begin
      @(negedge sys_clk);
      dpat[i] = 32'(mmio_done);
      rpat[i] = mmio_read_data;
    end
    @(posedge sys_clk); #2;
    mmio_read = 1'b0; mmio_write = 1'b0;
    for (int i = 0; i < 6; i++) chk("held_done", dpat[i], (i % 2 == 1) ? 32'd1 : 32'd0);
    chk("held_rd_first", rpat[1], 32'd0);
    chk("held_rd_2", rpat[3], 32'd1);
    chk("held_rd_3", rpat[5], 32'd1);

    @(posedge sys_clk); #2;
    wr(32'hFFFF_0380, 32'hFFFF_FFFF, 1'b0);
    chk("outwin_leds", 32'(leds_pin), 32'h1);
    wr(BASE + 32'h7C, 32'h1, 1'b1);
    chk("perbit31_leds", 32'(leds_pin), 32'h1);
    rd(BASE + 32'h7C, v);
    chk("perbit31_read", v, 32'h0);

`ifdef MMIO_LED_BANK_BLINK_EN
    wr(BASE + 32'h90, 32'h1, 1'b1);
    @(posedge sys_clk); #2;
    mmio_write = 1'b1; mmio_addr = BASE + 32'h94; mmio_write_data = 32'd4;
    @(posedge sys_clk); #2;
    mmio_write = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge sys_clk);
      chk("blink_div4", 32'(leds_pin[0]), ((i / 4) % 2 == 0) ? 32'd1 : 32'd0);
    end
    rd(BASE + 32'h94, v);
    chk("bdiv_read", v, 32'd4);
    wr(BASE + 32'h94, 32'd0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      @(negedge sys_clk);
      chk("blink_div0", 32'(leds_pin[0]), 32'd1);
    end
`else
    wr(BASE + 32'h90, 32'hFFFF, 1'b1);
    rd(BASE + 32'h90, v);
    chk("bmask_reserved", v, 32'd0);
    wr(BASE + 32'h94, 32'd3, 1'b1);
    rd(BASE + 32'h94, v);
    chk("bdiv_reserved", v, 32'd0);
`endif

    for (int k = 0; k < 400; k++) begin
      @(posedge sys_clk); #2;
      r = $urandom_range(0, 9);
      mmio_read  = 1'($urandom_range(0, 1));
      mmio_write = 1'($urandom_range(0, 1));
      mmio_write_data = $urandom;
      if (r == 0) mmio_addr = $urandom;
      else if (r <= 4) mmio_addr = {BASE[31:8], 1'b0, 5'($urandom), 2'($urandom)};
      else if (r <= 8) mmio_addr = BASE + 32'h80 + 32'(4 * $urandom_range(0, 5)) + 32'($urandom_range(0, 3));
      else mmio_addr = BASE + 32'h98 + 32'(4 * $urandom_range(0, 25));
      if (mmio_addr[7:0] == 8'h94 || mmio_addr[7:2] == 6'h25) mmio_write_data = $urandom_range(0, 6);
    end
    @(posedge sys_clk); #2;
    mmio_read = 1'b0; mmio_write = 1'b0;
    repeat (2) begin @(posedge sys_clk); #2; end

    wr(BASE + 32'h80, 32'h00AB_CDEF, 1'b1);
`ifdef MMIO_LED_BANK_BLINK_EN
    wr(BASE + 32'h90, 32'h00FF_FFFF, 1'b1);
    wr(BASE + 32'h94, 32'd3, 1'b1);
`endif
    @(posedge sys_clk); #2;
    mmio_write = 1'b1; mmio_read = 1'b1; mmio_addr = BASE + 32'h84; mmio_write_data = 32'h10;
    @(posedge sys_clk); #2;
    chk("abort_pre_done", 32'(mmio_done), 32'd1);
    rst = 1'b1;
    mmio_write = 1'b0; mmio_read = 1'b0;
    #1;
    chk("abort_leds", 32'(leds_pin), 32'd0);
    chk("abort_done", 32'(mmio_done), 32'd0);
    chk("abort_rdata", mmio_read_data, 32'd0);
    @(posedge sys_clk); #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      chk("post_rst_done", 32'(mmio_done), 32'd0);
      chk("post_rst_leds", 32'(leds_pin), 32'd0);
    end
    rd(BASE + 32'h80, v);
    chk("post_rst_word", v, 32'd0);

    @(posedge sys_clk);
    cmp_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
